// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: parity codes,
// FSM state encoding and a constant-width helper.
package uart_tx_fifo_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_GAP    = 3'd5
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with registered read data (valid the cycle after pop)
// and registered full/empty flags.
module sync_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [clog2(DEPTH):0]  count
);

    localparam int PTR_W = clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic [PTR_W:0]   count_next_s;
    logic [WIDTH-1:0] dout_r;
    logic             full_r;
    logic             empty_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify requests against the flags and compute the next occupancy.
    always_comb begin
        do_push_s    = push & ~full_r;
        do_pop_s     = pop & ~empty_r;
        count_next_s = count_r;
        case ({do_push_s, do_pop_s})
            2'b10:   count_next_s = count_r + {{PTR_W{1'b0}}, 1'b1};
            2'b01:   count_next_s = count_r - {{PTR_W{1'b0}}, 1'b1};
            default: count_next_s = count_r;
        endcase
    end

    // Storage array; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers, occupancy, flags and the registered read port.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
            dout_r   <= {WIDTH{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
                dout_r   <= mem_r[rd_ptr_r];
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == (PTR_W+1)'(DEPTH));
            empty_r <= (count_next_s == {(PTR_W+1){1'b0}});
        end
    end

    assign dout  = dout_r;
    assign full  = full_r;
    assign empty = empty_r;
    assign count = count_r;

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-fed UART transmitter with runtime bit period, parity, stop bits and
// inter-frame gap. Line outputs are registered, so they trail the FSM by one clock.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16,
    parameter int CPD_W     = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [CPD_W-1:0]        cycles_per_databit,
    input  logic [CPD_W-1:0]        spacing_limit,
    input  logic [1:0]              parity_mode,
    input  logic                    two_stop,
    input  logic [DATA_BITS-1:0]    tx_data,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    output logic                    tx_line,
    output logic                    tx_busy,
    output logic                    tx_done,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    localparam int IDX_W = clog2(DATA_BITS + 1);

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    state_t               state_r;
    state_t               state_next_s;
    logic [DATA_BITS-1:0] fifo_dout_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic                 pop_s;
    logic                 leave_stop_s;
    logic                 bit_end_s;
    logic                 last_stop_s;
    logic                 has_parity_s;
    logic                 line_s;
    logic                 done_s;

    logic [CPD_W-1:0]     cpd_r;
    logic [CPD_W-1:0]     spacing_r;
    logic [1:0]           parity_r;
    logic                 two_stop_r;
    logic [CPD_W-1:0]     bit_clk_r;
    logic [IDX_W-1:0]     bit_idx_r;
    logic [CPD_W-1:0]     gap_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 par_bit_r;
    logic                 stop_exit_r;
    logic                 tx_line_r;
    logic                 tx_done_r;
    logic                 tx_busy_r;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_valid),
        .pop   (pop_s),
        .din   (tx_data),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count)
    );

    assign bit_end_s    = (bit_clk_r == (cpd_r - CPD_W'(1)));
    assign last_stop_s  = two_stop_r ? (bit_idx_r == IDX_W'(1)) : 1'b1;
    assign has_parity_s = (parity_r == PAR_EVEN) || (parity_r == PAR_ODD);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            stop_exit_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            stop_exit_r <= leave_stop_s;
        end
    end

    // Next-state logic; the pop request is issued only from IDLE.
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        leave_stop_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s        = 1'b1;
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                state_next_s = bit_end_s ? ST_DATA : ST_START;
            end
            ST_DATA: begin
                if (bit_end_s && (bit_idx_r == IDX_W'(DATA_BITS - 1))) begin
                    state_next_s = has_parity_s ? ST_PARITY : ST_STOP;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                state_next_s = bit_end_s ? ST_STOP : ST_PARITY;
            end
            ST_STOP: begin
                if (bit_end_s && last_stop_s) begin
                    leave_stop_s = 1'b1;
                    state_next_s = (spacing_r != {CPD_W{1'b0}}) ? ST_GAP : ST_IDLE;
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            ST_GAP: begin
                if (bit_end_s && (gap_r == (spacing_r - CPD_W'(1)))) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_GAP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the current state, registered below.
    always_comb begin
        line_s = 1'b1;
        done_s = stop_exit_r;
        case (state_r)
            ST_START:  line_s = 1'b0;
            ST_DATA:   line_s = shift_r[0];
            ST_PARITY: line_s = par_bit_r;
            default:   line_s = 1'b1;
        endcase
    end

    // Registered serial outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_line_r <= 1'b1;
            tx_done_r <= 1'b0;
            tx_busy_r <= 1'b0;
        end else begin
            tx_line_r <= line_s;
            tx_done_r <= done_s;
            tx_busy_r <= (state_next_s != ST_IDLE);
        end
    end

    // Frame configuration is captured at pop so mid-frame edits wait for the next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpd_r      <= CPD_W'(1);
            spacing_r  <= {CPD_W{1'b0}};
            parity_r   <= PAR_NONE;
            two_stop_r <= 1'b0;
        end else if (pop_s) begin
            cpd_r      <= (cycles_per_databit == {CPD_W{1'b0}}) ? CPD_W'(1) : cycles_per_databit;
            spacing_r  <= spacing_limit;
            parity_r   <= parity_mode;
            two_stop_r <= two_stop;
        end else begin
            cpd_r      <= cpd_r;
            spacing_r  <= spacing_r;
            parity_r   <= parity_r;
            two_stop_r <= two_stop_r;
        end
    end

    // Bit-clock, bit-index and gap counters; all restart on every state change.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_clk_r <= {CPD_W{1'b0}};
            bit_idx_r <= {IDX_W{1'b0}};
            gap_r     <= {CPD_W{1'b0}};
        end else if ((state_next_s != state_r) || (state_r == ST_IDLE)) begin
            bit_clk_r <= {CPD_W{1'b0}};
            bit_idx_r <= {IDX_W{1'b0}};
            gap_r     <= {CPD_W{1'b0}};
        end else if (bit_end_s) begin
            bit_clk_r <= {CPD_W{1'b0}};
            bit_idx_r <= bit_idx_r + IDX_W'(1);
            gap_r     <= gap_r + CPD_W'(1);
        end else begin
            bit_clk_r <= bit_clk_r + CPD_W'(1);
            bit_idx_r <= bit_idx_r;
            gap_r     <= gap_r;
        end
    end

    // Read data is valid during START (registered FIFO port), so load there.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_r   <= {DATA_BITS{1'b0}};
            par_bit_r <= 1'b0;
        end else if (state_r == ST_START) begin
            shift_r   <= fifo_dout_s;
            par_bit_r <= parity_bit(fifo_dout_s, parity_r == PAR_ODD);
        end else if ((state_r == ST_DATA) && bit_end_s) begin
            shift_r   <= shift_r >> 1;
            par_bit_r <= par_bit_r;
        end else begin
            shift_r   <= shift_r;
            par_bit_r <= par_bit_r;
        end
    end

    assign tx_ready = ~fifo_full_s;
    assign tx_line  = tx_line_r;
    assign tx_busy  = tx_busy_r;
    assign tx_done  = tx_done_r;

endmodule
